// File: rtl/alu_pkg.sv
// alu_pkg: ALU operation/ALUOp encodings, FIFO entry type and funct decode function
package alu_pkg;
    typedef enum logic [3:0] {
        AND = 4'b0000,
        XOR = 4'b0001,
        ADD = 4'b0010,
        SUB = 4'b0011,
        SLL = 4'b0110,
        EQ  = 4'b1000,
        NOP = 4'b1111
    } alu_op_t;
    typedef enum logic [1:0] {LDST, BRANCH, RTYPE, ITYPE} aluop_t;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;
    typedef struct packed {
        alu_op_t op;
        logic    illegal;
    } entry_t;
    localparam entry_t ENTRY_RST = '{NOP, 1'b0};
    // Anything not matched falls through to NOP with illegal set.
    function automatic entry_t decode(aluop_t a, logic [2:0] f3, logic [6:0] f7);
        entry_t e;
        e = '{NOP, 1'b1};
        case (a)
            LDST:   e = '{ADD, 1'b0};
            BRANCH: if (f3 == 3'b000) e = '{EQ, 1'b0};
            RTYPE:
                case (f3)
                    3'b000: if (f7 == F7_BASE) e = '{ADD, 1'b0};
                            else if (f7 == F7_ALT) e = '{SUB, 1'b0};
                    3'b111: if (f7 == F7_BASE) e = '{AND, 1'b0};
                    3'b100: if (f7 == F7_BASE) e = '{XOR, 1'b0};
                    3'b001: if (f7 == F7_BASE) e = '{SLL, 1'b0};
                    default: ;
                endcase
            ITYPE:
                case (f3)
                    3'b000: e = '{ADD, 1'b0};
                    3'b111: e = '{AND, 1'b0};
                    3'b100: e = '{XOR, 1'b0};
                    3'b001: if (f7 == F7_BASE) e = '{SLL, 1'b0};
                    default: ;
                endcase
        endcase
        return e;
    endfunction
endpackage

// File: rtl/alu_op_issue_if.sv
// alu_op_issue_if: decode-side input channel and execute-side output channel
//   in_valid/in_ready + ALUOp/Funct3/Funct7 : decoded fields from the decode stage
//   out_valid/out_ready + Operation/illegal : queued ALU operation toward execute
//   master = environment view, slave = issue block view
interface alu_op_issue_if #(parameter int OPCODE_LENGTH = 4);
    logic                     in_valid;
    logic                     in_ready;
    logic [1:0]               ALUOp;
    logic [2:0]               Funct3;
    logic [6:0]               Funct7;
    logic                     out_valid;
    logic                     out_ready;
    logic [OPCODE_LENGTH-1:0] Operation;
    logic                     illegal;
    modport master (
        output in_valid, ALUOp, Funct3, Funct7, out_ready,
        input  in_ready, out_valid, Operation, illegal
    );
    modport slave (
        input  in_valid, ALUOp, Funct3, Funct7, out_ready,
        output in_ready, out_valid, Operation, illegal
    );
endinterface

// File: rtl/alu_op_issue_fifo2.sv
// alu_op_fifo2: 2-entry register FIFO with valid/ready on both sides
//   clk, rst_n                    : clock, async active-low reset
//   in_valid/in_ready/in_data     : write channel (in_ready from registered count only)
//   out_valid/out_ready/out_data  : read channel, out_data is the head entry
module alu_op_fifo2 #(
    parameter int           W       = 5,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    logic [W-1:0] mem [2];
    logic         wp, rp;
    logic [1:0]   count;
    logic         push, pop;
    assign in_ready  = count != 2'd2;
    assign out_valid = count != 2'd0;
    assign out_data  = mem[rp];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= RST_VAL;
            mem[1] <= RST_VAL;
            wp     <= 1'b0;
            rp     <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) mem[wp] <= in_data;
            if (push) wp <= ~wp;
            if (pop) rp <= ~rp;
            count <= count + 2'(push) - 2'(pop);
        end
    end
endmodule

// File: rtl/alu_op_issue.sv
// alu_op_issue: decodes ALUOp/Funct3/Funct7 into an ALU operation, queues it, counts illegal entries
//   clk, rst_n     : clock, async active-low reset
//   bus            : alu_op_issue_if slave (input fields channel, output operation channel)
//   clr_count      : synchronous clear of illegal_count, wins over an increment
//   illegal_count  : saturating count of accepted illegal entries
module alu_op_issue import alu_pkg::*; #(
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_issue_if.slave        bus,
    input  logic                 clr_count,
    output logic [CNT_WIDTH-1:0] illegal_count
);
    entry_t dec, head;
    logic   push;
    assign dec  = decode(aluop_t'(bus.ALUOp), bus.Funct3, bus.Funct7);
    assign push = bus.in_valid & bus.in_ready;
    alu_op_fifo2 #(.W($bits(entry_t)), .RST_VAL(ENTRY_RST)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (head)
    );
    assign bus.Operation = OPCODE_LENGTH'(head.op);
    assign bus.illegal   = head.illegal;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) illegal_count <= '0;
        else if (clr_count) illegal_count <= '0;
        else if (push && dec.illegal && !(&illegal_count)) illegal_count <= illegal_count + CNT_WIDTH'(1);
    end
endmodule

// File: tb/tb_alu_op_issue.sv
// tb_alu_op_issue: directed vectors for alu_op_issue decode, FIFO handshake, counter and reset
module tb_alu_op_issue;
    typedef struct packed {
        logic [1:0] a;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] op;
        logic       ill;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr_count = 1'b0;
    logic [15:0] illegal_count;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_cnt = 0;

    vec_t vecs [17] = '{
        '{2'b10, 3'b000, 7'h00, 4'h2, 1'b0},
        '{2'b10, 3'b000, 7'h20, 4'h3, 1'b0},
        '{2'b10, 3'b000, 7'h01, 4'hf, 1'b1},
        '{2'b10, 3'b111, 7'h00, 4'h0, 1'b0},
        '{2'b10, 3'b111, 7'h20, 4'hf, 1'b1},
        '{2'b10, 3'b100, 7'h00, 4'h1, 1'b0},
        '{2'b10, 3'b001, 7'h00, 4'h6, 1'b0},
        '{2'b10, 3'b001, 7'h20, 4'hf, 1'b1},
        '{2'b10, 3'b010, 7'h00, 4'hf, 1'b1},
        '{2'b11, 3'b000, 7'h7f, 4'h2, 1'b0},
        '{2'b11, 3'b111, 7'h20, 4'h0, 1'b0},
        '{2'b11, 3'b100, 7'h55, 4'h1, 1'b0},
        '{2'b11, 3'b001, 7'h20, 4'hf, 1'b1},
        '{2'b11, 3'b101, 7'h00, 4'hf, 1'b1},
        '{2'b01, 3'b000, 7'h33, 4'h8, 1'b0},
        '{2'b01, 3'b111, 7'h00, 4'hf, 1'b1},
        '{2'b00, 3'b101, 7'h7f, 4'h2, 1'b0}
    };

    alu_op_issue_if #(.OPCODE_LENGTH(4)) bus ();

    alu_op_issue #(.OPCODE_LENGTH(4), .CNT_WIDTH(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .clr_count     (clr_count),
        .illegal_count (illegal_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [1:0] a, input logic [2:0] f3, input logic [6:0] f7);
        bus.in_valid = v;
        bus.ALUOp    = a;
        bus.Funct3   = f3;
        bus.Funct7   = f7;
    endtask

    initial begin
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        bus.out_ready = 1'b0;
        #12;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_operation", 32'(bus.Operation), 32'hf);
        chk("rst_illegal", 32'(bus.illegal), 0);
        chk("rst_count", 32'(illegal_count), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // SUB through an empty FIFO, one cycle latency
        bus.out_ready = 1'b1;
        set_in(1'b1, 2'b10, 3'b000, 7'h20);
        tick();
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        chk("t1_out_valid", 32'(bus.out_valid), 1);
        chk("t1_operation", 32'(bus.Operation), 32'h3);
        chk("t1_illegal", 32'(bus.illegal), 0);
        tick();
        chk("t1_drained", 32'(bus.out_valid), 0);

        // fill to 2 with back-pressure, then drain in order
        bus.out_ready = 1'b0;
        set_in(1'b1, 2'b00, 3'b101, 7'h7f);
        tick();
        chk("t2_ready_after_1", 32'(bus.in_ready), 1);
        set_in(1'b1, 2'b11, 3'b001, 7'h00);
        tick();
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        chk("t2_full_ready", 32'(bus.in_ready), 0);
        chk("t2_head", 32'(bus.Operation), 32'h2);
        tick();
        chk("t2_hold", 32'(bus.Operation), 32'h2);
        chk("t2_hold_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_second", 32'(bus.Operation), 32'h6);
        chk("t2_second_valid", 32'(bus.out_valid), 1);
        chk("t2_slot_freed", 32'(bus.in_ready), 1);
        tick();
        chk("t2_drained", 32'(bus.out_valid), 0);

        // illegal branch entry is delivered and counted
        bus.out_ready = 1'b0;
        set_in(1'b1, 2'b01, 3'b001, 7'h00);
        tick();
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        exp_cnt = 1;
        chk("t3_operation", 32'(bus.Operation), 32'hf);
        chk("t3_illegal", 32'(bus.illegal), 1);
        chk("t3_count", 32'(illegal_count), 32'(exp_cnt));
        bus.out_ready = 1'b1;
        tick();
        chk("t3_drained", 32'(bus.out_valid), 0);

        // decode table streamed with push and pop every cycle at count=1
        foreach (vecs[i]) begin
            set_in(1'b1, vecs[i].a, vecs[i].f3, vecs[i].f7);
            tick();
            if (vecs[i].ill) exp_cnt++;
            chk($sformatf("t5_op_%0d", i), 32'(bus.Operation), 32'(vecs[i].op));
            chk($sformatf("t5_ill_%0d", i), 32'(bus.illegal), 32'(vecs[i].ill));
            chk($sformatf("t5_valid_%0d", i), 32'(bus.out_valid), 1);
            chk($sformatf("t5_ready_%0d", i), 32'(bus.in_ready), 1);
        end
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        chk("t5_count", 32'(illegal_count), 32'(exp_cnt));
        tick();
        chk("t5_drained", 32'(bus.out_valid), 0);

        // saturation and clear-wins
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        chk("t4_cleared", 32'(illegal_count), 0);
        set_in(1'b1, 2'b01, 3'b001, 7'h00);
        repeat (65535) @(posedge clk);
        #1;
        chk("t4_all_ones", 32'(illegal_count), 32'hffff);
        tick();
        chk("t4_saturated", 32'(illegal_count), 32'hffff);
        clr_count = 1'b1;
        tick();
        clr_count = 1'b0;
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        chk("t4_clear_wins", 32'(illegal_count), 0);
        chk("t4_still_delivered", 32'(bus.illegal), 1);
        tick();
        chk("t4_drained", 32'(bus.out_valid), 0);

        // asynchronous reset with two entries queued
        bus.out_ready = 1'b0;
        set_in(1'b1, 2'b01, 3'b111, 7'h00);
        tick();
        tick();
        set_in(1'b0, 2'b00, 3'b000, 7'h00);
        chk("t6_full", 32'(bus.in_ready), 0);
        chk("t6_count", 32'(illegal_count), 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_out_valid", 32'(bus.out_valid), 0);
        chk("t6_count_rst", 32'(illegal_count), 0);
        chk("t6_operation", 32'(bus.Operation), 32'hf);
        chk("t6_illegal", 32'(bus.illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_in_ready", 32'(bus.in_ready), 1);
        chk("t6_empty", 32'(bus.out_valid), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
